// File: rtl/scie_fir_pipelined.sv
// FIR-filter custom-instruction unit: SETCOEF / PUSH / READ with a one-cycle result latency.
// Optional macro SCIE_FIR_SAT_EN: wide accumulation with saturation of the READ result.
module scie_fir_pipelined #(
    parameter int unsigned NTAPS = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd
);

    localparam int unsigned IDXW = $clog2(NTAPS);

    localparam logic [6:0] OP_SETCOEF = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_READ    = 7'h3B;

    logic [XLEN-1:0] r_coef [NTAPS];
    logic [XLEN-1:0] r_x    [NTAPS];
    logic [XLEN-1:0] r_rd;
    logic [XLEN-1:0] w_sum;
    logic [IDXW-1:0] w_idx;
    logic [6:0]      w_op;
    logic            w_unused;

    assign w_op     = io_insn[6:0];
    assign w_idx    = io_rs2[IDXW-1:0];
    assign w_unused = ^{io_insn[31:7], io_rs2[XLEN-1:IDXW]};

`ifdef SCIE_FIR_SAT_EN
    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned ACCW = 2 * XLEN + IDXW;

    logic [ACCW-1:0] w_acc;

    // Full-precision dot product, clamped to the largest XLEN value on overflow.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_acc = w_acc + ACCW'(PW'(r_coef[i]) * PW'(r_x[i]));
        end
        w_sum = (|w_acc[ACCW-1:XLEN]) ? {XLEN{1'b1}} : w_acc[XLEN-1:0];
    end
`else
    // Dot product with every product and partial sum truncated to XLEN bits.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_sum = w_sum + XLEN'(r_coef[i] * r_x[i]);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
                r_x[i]    <= '0;
            end
            r_rd <= '0;
        end else if (io_valid) begin
            case (w_op)
                OP_SETCOEF: r_coef[w_idx] <= io_rs1;
                OP_PUSH: begin
                    r_x[0] <= io_rs1;
                    for (int i = 1; i < NTAPS; i++) begin
                        r_x[i] <= r_x[i-1];
                    end
                end
                OP_READ: r_rd <= w_sum;
                default: ;
            endcase
        end
    end

    assign io_rd = r_rd;

endmodule

// File: tb/tb_scie_fir_pipelined.sv
// Self-checking bench for scie_fir_pipelined: directed scenarios plus randomized
// instruction streams compared against a queue-based dot-product model.
module tb_scie_fir_pipelined;

    localparam int unsigned NTAPS = 4;
    localparam int unsigned XLEN  = 32;

    localparam logic [6:0] OP_SETCOEF = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_READ    = 7'h3B;
    localparam logic [6:0] OP_UNK     = 7'h7B;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_valid;
    logic [31:0]     io_insn;
    logic [XLEN-1:0] io_rs1;
    logic [XLEN-1:0] io_rs2;
    logic [XLEN-1:0] io_rd;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: coefficient table, newest-first sample queue, last result.
    logic [31:0] m_coef [NTAPS];
    logic [31:0] m_x    [$];
    logic [31:0] m_rd;

    scie_fir_pipelined #(.NTAPS(NTAPS), .XLEN(XLEN)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_valid (io_valid),
        .io_insn  (io_insn),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_rd    (io_rd)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_coef[i]) m_coef[i] = '0;
        m_x.delete();
        for (int i = 0; i < NTAPS; i++) m_x.push_back(32'd0);
        m_rd = '0;
    endtask

    function automatic logic [31:0] model_dot();
        logic [127:0] acc;
        acc = '0;
        for (int i = 0; i < NTAPS; i++) acc += 128'(m_coef[i]) * 128'(m_x[i]);
`ifdef SCIE_FIR_SAT_EN
        return (acc > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0];
`else
        return acc[31:0];
`endif
    endfunction

    // One clock cycle: drive at negedge, update model at the edge, check io_rd at the next negedge.
    task automatic step(input logic v, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rst);
        logic [31:0] hi;
        hi       = $urandom();
        reset    = rst;
        io_valid = v;
        io_insn  = {hi[31:7], op};
        io_rs1   = a;
        io_rs2   = b;
        @(posedge clock);
        if (rst) begin
            model_clear();
        end else if (v) begin
            case (op)
                OP_SETCOEF: m_coef[b % NTAPS] = a;
                OP_PUSH: begin
                    m_x.push_front(a);
                    void'(m_x.pop_back());
                end
                OP_READ: m_rd = model_dot();
                default: ;
            endcase
        end
        @(negedge clock);
        reset    = 1'b0;
        io_valid = 1'b0;
        check_eq("io_rd", io_rd, m_rd);
    endtask

    task automatic setcoef(input logic [31:0] v, input logic [31:0] idx); step(1'b1, OP_SETCOEF, v, idx, 1'b0); endtask
    task automatic push(input logic [31:0] v);  step(1'b1, OP_PUSH, v, $urandom(), 1'b0); endtask
    task automatic rd();                        step(1'b1, OP_READ, $urandom(), $urandom(), 1'b0); endtask
    task automatic idle();                      step(1'b0, OP_READ, $urandom(), $urandom(), 1'b0); endtask
    task automatic rst_cycle();                 step(1'b1, OP_READ, $urandom(), $urandom(), 1'b1); endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [6:0] ops [5];
        ops = '{OP_SETCOEF, OP_PUSH, OP_READ, OP_UNK, 7'h33};
        reset = 1'b1; io_valid = 1'b0; io_insn = '0; io_rs1 = '0; io_rs2 = '0;
        model_clear();
        repeat (2) @(negedge clock);
        check_eq("reset_rd", io_rd, 32'd0);

        // Basic two-tap response.
        setcoef(32'd18, 32'd0);
        setcoef(32'd36, 32'd1);
        push(32'd46);
        idle();
        rd();
        check_eq("t1_read", io_rd, 32'd828);

        push(32'd27);
        idle();
        rd();
        check_eq("t2_read", io_rd, 32'd2142);
        repeat (3) idle();
        check_eq("t2_hold", io_rd, 32'd2142);

        // Reset wins over a simultaneous READ; invalid READ opcode is ignored.
        rst_cycle();
        check_eq("t3_rst", io_rd, 32'd0);
        rd();
        check_eq("t3_read0", io_rd, 32'd0);
        setcoef(32'd5, 32'd0);
        push(32'd7);
        rd();
        check_eq("t3_read35", io_rd, 32'd35);
        push(32'd3);
        step(1'b0, OP_READ, 32'd0, 32'd0, 1'b0);
        check_eq("t3_noval", io_rd, 32'd35);
        rd();
        check_eq("t3_read15", io_rd, 32'd15);

        // Coefficient index wraps modulo NTAPS.
        rst_cycle();
        setcoef(32'd10, 32'd5);
        push(32'd3);
        push(32'd0);
        rd();
        check_eq("t4_wrapidx", io_rd, 32'd30);

        // Oldest sample drops out of the delay line.
        rst_cycle();
        for (int k = 4; k < 8; k++) setcoef(32'd1, 32'(k));
        for (int s = 1; s <= 5; s++) push(32'(s));
        rd();
        check_eq("t4_drop", io_rd, 32'd14);

        // Overflow behaviour.
        rst_cycle();
        setcoef(32'hFFFF_FFFF, 32'd0);
        push(32'd2);
        rd();
`ifdef SCIE_FIR_SAT_EN
        check_eq("t5_sat", io_rd, 32'hFFFF_FFFF);
`else
        check_eq("t5_wrap", io_rd, 32'hFFFF_FFFE);
`endif

        // Unknown opcode between PUSH and READ changes nothing.
        rst_cycle();
        setcoef(32'd3, 32'd0);
        push(32'd4);
        step(1'b1, OP_UNK, 32'd99, 32'd0, 1'b0);
        rd();
        check_eq("t6_unk", io_rd, 32'd12);

        // Randomized back-to-back instruction stream.
        rst_cycle();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_cycle();
            end else begin
                step(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 4)],
                     rand_val(), $urandom(), 1'b0);
            end
        end
        rd();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
